// File: rtl/load_unit_pkg.sv
// Shared load-unit definitions: load_op encoding used by the controller,
// FSM state type and the alignment rule.
package load_unit_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] LWU = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        ERR
    } state_t;

    // op[1] set selects a word access; otherwise op[0] selects halfword.
    function automatic logic is_misaligned(input logic [2:0] op,
                                           input logic [1:0] off);
        if (op[1])
            return off != 2'b00;
        else if (op[1:0] == LH[1:0])
            return off[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Byte/halfword lane selection from a little-endian word and sign or
// zero extension to 32 bits.
module load_extend
    import load_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        sext;
    logic        is_word;
    logic        is_half;
    logic        is_byte;

    assign shifted  = word >> {offset, 3'b000};
    assign byte_val = shifted[7:0];
    assign half_val = offset[1] ? word[31:16] : word[15:0];
    assign sext     = (op[2] == LB[2]);
    assign is_word  = op[1];
    assign is_half  = !op[1] && (op[0] == LH[0]);
    assign is_byte  = !op[1] && (op[0] == LB[0]);

    always_comb begin
        result = word;
        unique case (1'b1)
            is_word: result = word;
            is_half: result = {{16{sext & half_val[15]}}, half_val};
            is_byte: result = {{24{sext & byte_val[7]}}, byte_val};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: one memory read per accepted start, with alignment check,
// bounded wait for acknowledge, and extended result register.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [2:0]  load_op,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        timeout_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next;
    logic [7:0]  cnt;
    logic [1:0]  lat_off;
    logic [2:0]  lat_op;
    logic        to_flag;
    logic [31:0] ext;
    logic        accept;
    logic        expire;

    assign accept = (state == IDLE) && start;
    assign expire = (state == REQ) && !mem_ack && (cnt == LAST);

    load_extend u_ext (
        .word   (mem_rdata),
        .offset (lat_off),
        .op     (lat_op),
        .result (ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_off   <= '0;
            lat_op    <= '0;
            to_flag   <= 1'b0;
            mem_addr  <= '0;
            load_data <= '0;
        end else begin
            state <= next;
            if (accept) begin
                lat_off  <= addr[1:0];
                lat_op   <= load_op;
                mem_addr <= {addr[31:2], 2'b00};
                to_flag  <= 1'b0;
            end
            if (state != REQ)
                cnt <= '0;
            else if (!mem_ack)
                cnt <= cnt + 8'd1;
            // Result lands with the RESP entry so it is valid alongside done.
            if (state == REQ && mem_ack)
                load_data <= ext;
            if (expire)
                to_flag <= 1'b1;
        end
    end

    always_comb begin
        next        = state;
        busy        = 1'b1;
        mem_req     = 1'b0;
        done        = 1'b0;
        misalign    = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    next = is_misaligned(load_op, addr[1:0]) ? ERR : REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack)
                    next = RESP;
                else if (cnt == LAST)
                    next = ERR;
            end
            RESP: begin
                done = 1'b1;
                next = IDLE;
            end
            ERR: begin
                misalign    = !to_flag;
                timeout_err = to_flag;
                next        = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: stimulus pushes expected outcomes into a
// queue, an independent monitor pops them whenever a result pulse appears.
module tb_load_unit;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] addr;
    logic [2:0]  load_op;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misalign;
    logic        timeout_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int compared   = 0;
    int mismatched = 0;
    exp_t        q[$];
    logic [31:0] last_data;

    load_unit #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .addr        (addr),
        .load_op     (load_op),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data),
        .misalign    (misalign),
        .timeout_err (timeout_err),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: one-hot kind {timeout_err, misalign, done} plus load_data.
    always @(negedge clk) begin
        if (!rst && (done || misalign || timeout_err)) begin
            if (q.size() == 0) begin
                check("unexpected_pulse",
                      {29'b0, timeout_err, misalign, done}, 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_kind", {29'b0, timeout_err, misalign, done},
                      {29'b0, e.kind});
                check("event_data", load_data, e.data);
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input logic [2:0] op,
                           input logic [31:0] rdata, input int delay,
                           input logic [31:0] exp_data);
        start   = 1'b1;
        addr    = a;
        load_op = op;
        q.push_back({3'b001, exp_data});
        tick();
        start   = 1'b0;
        addr    = $urandom;
        load_op = 3'($urandom_range(0, 7));
        check("req_cycle1", {31'b0, mem_req}, 32'h1);
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        for (int i = 0; i < delay; i++) begin
            tick();
        end
        check("req_before_ack", {31'b0, mem_req}, 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        check("done_cycle", {31'b0, done}, 32'h1);
        tick();
        check("idle_after_done", {31'b0, busy}, 32'h0);
        last_data = exp_data;
    endtask

    task automatic do_misalign(input logic [31:0] a, input logic [2:0] op);
        start   = 1'b1;
        addr    = a;
        load_op = op;
        q.push_back({3'b010, last_data});
        tick();
        start = 1'b0;
        check("mis_busy", {31'b0, busy}, 32'h1);
        check("mis_no_req", {31'b0, mem_req}, 32'h0);
        tick();
        check("mis_busy_1cyc", {31'b0, busy}, 32'h0);
        check("mis_no_req2", {31'b0, mem_req}, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'h0);
        check({tag, "_done"}, {31'b0, done}, 32'h0);
        check({tag, "_misalign"}, {31'b0, misalign}, 32'h0);
        check({tag, "_timeout"}, {31'b0, timeout_err}, 32'h0);
        check({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
        check({tag, "_load_data"}, load_data, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int reqs;
        int req_cyc[2];
        int done_cyc;

        rst       = 1'b1;
        start     = 1'b0;
        addr      = '0;
        load_op   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        last_data = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        do_load(32'h0000_0103, 3'd0, 32'h80AA_BBCC, 0, 32'hFFFF_FF80);
        do_load(32'h0000_0022, 3'd5, 32'hF00D_1234, 3, 32'h0000_F00D);
        do_load(32'h0000_0002, 3'd1, 32'h8001_1234, 1, 32'hFFFF_8001);
        do_load(32'h0000_0101, 3'd4, 32'h80AA_BBCC, 0, 32'h0000_00BB);
        do_load(32'h0000_0040, 3'd2, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
        do_load(32'h0000_0204, 3'd7, 32'h1234_5678, 0, 32'h1234_5678);
        do_load(32'h0000_0012, 3'd1, 32'h7FFF_0000, 0, 32'h0000_7FFF);

        do_misalign(32'h0000_0041, 3'd2);
        do_misalign(32'h0000_0003, 3'd1);

        // Never acknowledged: request held TIMEOUT cycles, then timeout.
        start   = 1'b1;
        addr    = 32'h0000_0080;
        load_op = 3'd2;
        q.push_back({3'b100, last_data});
        tick();
        start = 1'b0;
        n = 0;
        while (mem_req && n < 300) begin
            n++;
            tick();
        end
        check("timeout_req_cycles", 32'(n), 32'd16);
        check("timeout_pulse", {31'b0, timeout_err}, 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check("timeout_idle", {31'b0, busy}, 32'h0);
        check("timeout_data_kept", load_data, last_data);

        // Reset during REQ, late ack afterwards.
        start   = 1'b1;
        addr    = 32'h0000_0005;
        load_op = 3'd0;
        tick();
        start = 1'b0;
        check("rst_mid_req", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        check_reset_outputs("post_rst");
        tick();
        check_reset_outputs("post_rst2");
        last_data = '0;

        // start held across two LB loads.
        start     = 1'b1;
        addr      = 32'h0000_0010;
        load_op   = 3'd0;
        reqs      = 0;
        done_cyc  = -1;
        req_cyc   = '{-1, -1};
        q.push_back({3'b001, 32'h0000_007F});
        q.push_back({3'b001, 32'hFFFF_FF81});
        for (int c = 1; c <= 12; c++) begin
            tick();
            mem_ack = 1'b0;
            if (done && done_cyc < 0)
                done_cyc = c;
            if (mem_req) begin
                if (reqs < 2)
                    req_cyc[reqs] = c;
                reqs++;
                mem_ack   = 1'b1;
                mem_rdata = (reqs == 1) ? 32'h0000_007F : 32'h0000_0081;
                if (reqs == 2)
                    start = 1'b0;
            end
        end
        mem_ack = 1'b0;
        check("b2b_req_count", 32'(reqs), 32'd2);
        check("b2b_req1_cycle", 32'(req_cyc[0]), 32'd1);
        check("b2b_done1_cycle", 32'(done_cyc), 32'd2);
        check("b2b_req2_cycle", 32'(req_cyc[1]), 32'd4);
        check("b2b_final_data", load_data, 32'hFFFF_FF81);

        repeat (3) tick();
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
